// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: channel state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package key_debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_HELD       = 3'd3,
        ST_RELEASE_DB = 3'd4
    } key_state_t;

    // Bits needed to count up to the larger of the long-press and debounce thresholds.
    function automatic int cnt_width(input int long_ms, input int db_ms);
        int m;
        m = (long_ms > db_ms) ? long_ms : db_ms;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce/hold state machine, registered event pulses.
// Latency: 2 clocks sync + DEBOUNCE_MS samples + 1 clock to key_press.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
module key_debounce_chan #(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic sample,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    import key_debounce_pkg::*;

    localparam int            CW       = cnt_width(LONG_MS, DEBOUNCE_MS);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] DB_TGT   = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] LONG_TGT = CW'(LONG_MS - DEBOUNCE_MS);

    logic          key_norm;
    logic [1:0]    sync_q;
    logic          pressed;
    key_state_t    state;
    logic          was_held;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] db_inc;
    logic [CW-1:0] hold_inc;

    // Normalise before synchronising so the reset value 0 means "released".
    assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
    assign pressed  = sync_q[1];

    // Saturating increments: counters never wrap.
    assign db_inc   = (db_cnt == CNT_MAX)   ? db_cnt   : db_cnt + CW'(1);
    assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CW'(1);

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_norm};
        end
    end

    // Channel state machine; advances only on sample cycles, pulses default low every clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            was_held    <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
            if (sample) begin
                case (state)
                    ST_IDLE: begin
                        if (pressed) begin
                            if (DEBOUNCE_MS == 1) begin
                                state     <= ST_PRESSED;
                                key_press <= 1'b1;
                                key_level <= 1'b1;
                                hold_cnt  <= '0;
                            end else begin
                                state  <= ST_PRESS_DB;
                                db_cnt <= CW'(1);
                            end
                        end
                    end
                    ST_PRESS_DB: begin
                        if (pressed) begin
                            if (db_inc == DB_TGT) begin
                                state     <= ST_PRESSED;
                                key_press <= 1'b1;
                                key_level <= 1'b1;
                                hold_cnt  <= '0;
                                db_cnt    <= '0;
                            end else begin
                                db_cnt <= db_inc;
                            end
                        end else begin
                            state  <= ST_IDLE;
                            db_cnt <= '0;
                        end
                    end
                    ST_PRESSED, ST_HELD: begin
                        if (pressed) begin
                            if (state == ST_PRESSED) begin
                                if (hold_inc == LONG_TGT) begin
                                    state    <= ST_HELD;
                                    key_long <= 1'b1;
                                    hold_cnt <= '0;
                                end else begin
                                    hold_cnt <= hold_inc;
                                end
                            end else if (REPEAT_MS != 0 && int'(hold_inc) == REPEAT_MS) begin
                                key_repeat <= 1'b1;
                                hold_cnt   <= '0;
                            end else begin
                                hold_cnt <= hold_inc;
                            end
                        end else if (DEBOUNCE_MS == 1) begin
                            state       <= ST_IDLE;
                            key_release <= 1'b1;
                            key_level   <= 1'b0;
                            hold_cnt    <= '0;
                            db_cnt      <= '0;
                        end else begin
                            // hold_cnt is left untouched so a bounce can resume the hold timing.
                            state    <= ST_RELEASE_DB;
                            was_held <= (state == ST_HELD);
                            db_cnt   <= CW'(1);
                        end
                    end
                    ST_RELEASE_DB: begin
                        if (!pressed) begin
                            if (db_inc == DB_TGT) begin
                                state       <= ST_IDLE;
                                key_release <= 1'b1;
                                key_level   <= 1'b0;
                                db_cnt      <= '0;
                                hold_cnt    <= '0;
                            end else begin
                                db_cnt <= db_inc;
                            end
                        end else begin
                            state  <= was_held ? ST_HELD : ST_PRESSED;
                            db_cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        key_level <= 1'b0;
                        db_cnt    <= '0;
                        hold_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS buttons, sampling on each rising edge of the 1 kHz divider output.
// Latency: 1 clock tick edge detect, then per-channel latency of key_debounce_chan.
// Backpressure: none; all event outputs are single-cycle pulses.
module key_debounce #(
    parameter int NUM_KEYS       = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick_1k,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);
    import key_debounce_pkg::*;

    logic tick_q;
    logic sample;

    // One sample enable per rising edge of the 1 kHz square wave.
    assign sample = tick_1k & ~tick_q;

    // Delay the tick by one clock for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_1k;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .LONG_MS        (LONG_MS),
            .REPEAT_MS      (REPEAT_MS)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .sample      (sample),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule
